// File: rtl/bus_reg_bank.sv
// Host-bus register bank: NUM_REGS R/W registers, a sticky W1C STATUS and IRQ_EN.
// Asynchronous host strobes are synchronised into clk; writes commit on the WR_ rising edge.
module bus_reg_bank #(
  parameter int                  DW          = 8,
  parameter int                  AW          = 8,
  parameter int                  NUM_REGS    = 4,
  parameter logic [AW-1:0]       BASE_ADDR   = '0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
  parameter int                  SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   CS_,
  input  logic                   OE_,
  input  logic                   WR_,
  input  logic [AW-1:0]          Addr,
  inout  wire  [DW-1:0]          data_bus,
  input  logic [DW-1:0]          evt_in,
  output logic [NUM_REGS*DW-1:0] reg_q,
  output logic                   wr_pulse,
  output logic                   rd_pulse,
  output logic                   irq
);
  localparam int            S        = SYNC_STAGES;
  localparam logic [AW-1:0] STAT_OFF = AW'(NUM_REGS);
  localparam logic [AW-1:0] IEN_OFF  = AW'(NUM_REGS + 1);

  logic [S-1:0]  cs_s_q, oe_s_q, wr_s_q;
  logic [AW-1:0] addr_s_q [S];
  logic [DW-1:0] din_s_q [S];
  logic          oe_d_q, wr_d_q;
  logic [S:0]    vld_q;

  // vld_q marks when every stage holds a post-reset sample, so reset artefacts never look like edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_s_q <= '1;
      oe_s_q <= '1;
      wr_s_q <= '1;
      oe_d_q <= 1'b1;
      wr_d_q <= 1'b1;
      vld_q  <= '0;
      for (int i = 0; i < S; i++) begin
        addr_s_q[i] <= '0;
        din_s_q[i]  <= '0;
      end
    end else begin
      cs_s_q      <= {cs_s_q[S-2:0], CS_};
      oe_s_q      <= {oe_s_q[S-2:0], OE_};
      wr_s_q      <= {wr_s_q[S-2:0], WR_};
      oe_d_q      <= oe_s_q[S-1];
      wr_d_q      <= wr_s_q[S-1];
      vld_q       <= {vld_q[S-1:0], 1'b1};
      addr_s_q[0] <= Addr;
      din_s_q[0]  <= data_bus;
      for (int i = 1; i < S; i++) begin
        addr_s_q[i] <= addr_s_q[i-1];
        din_s_q[i]  <= din_s_q[i-1];
      end
    end
  end

  logic          cs_n, oe_n, wr_n, edge_ok;
  logic          wr_rise, wr_fall, oe_fall, rd_latch, drive, commit;
  logic          sel_reg, sel_stat, sel_ien;
  logic [AW-1:0] offset;
  logic [DW-1:0] din_c, rd_mux, status_d;

  assign cs_n     = cs_s_q[S-1];
  assign oe_n     = oe_s_q[S-1];
  assign wr_n     = wr_s_q[S-1];
  assign din_c    = din_s_q[S-1];
  assign offset   = addr_s_q[S-1] - BASE_ADDR;
  assign edge_ok  = vld_q[S];
  assign wr_fall  = edge_ok & wr_d_q & ~wr_n;
  assign wr_rise  = edge_ok & ~wr_d_q & wr_n;
  assign oe_fall  = edge_ok & oe_d_q & ~oe_n;
  assign sel_reg  = (offset < STAT_OFF);
  assign sel_stat = (offset == STAT_OFF);
  assign sel_ien  = (offset == IEN_OFF);

  // Strobe protocol: a write is WR_ falling then rising with CS_ low throughout; any CS_ high
  // during the strobe abandons it. A read is an OE_ falling edge with CS_ low and WR_ high.
  typedef enum logic {WS_IDLE, WS_STROBE} wr_state_e;
  wr_state_e wr_state_q, wr_state_d;

  always_comb begin
    wr_state_d = wr_state_q;
    commit     = 1'b0;
    case (wr_state_q)
      WS_IDLE: if (wr_fall && !cs_n) wr_state_d = WS_STROBE;
      WS_STROBE: begin
        if (cs_n) begin
          wr_state_d = WS_IDLE;
        end else if (wr_rise) begin
          wr_state_d = WS_IDLE;
          commit     = 1'b1;
        end
      end
      default: wr_state_d = WS_IDLE;
    endcase
  end

  logic [DW-1:0] regs_q [NUM_REGS];
  logic [DW-1:0] status_q, irq_en_q, rd_data_q;
  logic          wr_pulse_q, rd_pulse_q, irq_q;

  always_comb begin
    rd_mux = '0;
    if (sel_reg) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (offset == AW'(i)) rd_mux = regs_q[i];
    end else if (sel_stat) begin
      rd_mux = status_q;
    end else if (sel_ien) begin
      rd_mux = irq_en_q;
    end
  end

  assign rd_latch = oe_fall & ~cs_n & wr_n;
  // Events are ORed in after the clear so a same-cycle event survives a W1C.
  assign status_d = (status_q & ~((commit && sel_stat) ? din_c : '0)) | evt_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= WS_IDLE;
      status_q   <= '0;
      irq_en_q   <= '0;
      rd_data_q  <= '0;
      wr_pulse_q <= 1'b0;
      rd_pulse_q <= 1'b0;
      irq_q      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      status_q   <= status_d;
      irq_q      <= |(status_q & irq_en_q);
      wr_pulse_q <= commit && (sel_reg || sel_stat || sel_ien);
      rd_pulse_q <= rd_latch;
      if (commit && sel_ien) irq_en_q <= din_c;
      if (rd_latch) rd_data_q <= rd_mux;
      for (int i = 0; i < NUM_REGS; i++)
        if (commit && sel_reg && offset == AW'(i) && !RO_MASK[i]) regs_q[i] <= din_c;
    end
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_q[i*DW +: DW] = regs_q[i];
  end

  assign drive    = edge_ok & ~cs_n & ~oe_n & wr_n;
  assign data_bus = drive ? rd_data_q : 'z;
  assign wr_pulse = wr_pulse_q;
  assign rd_pulse = rd_pulse_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_bus_reg_bank.sv
// Directed bench for bus_reg_bank: bus write/read tasks, read-data scoreboard queue, summary.
module tb_bus_reg_bank;
  localparam int            DW   = 8;
  localparam int            AW   = 8;
  localparam int            NR   = 4;
  localparam int            S    = 2;
  localparam int            LAT  = S + 1;
  localparam logic [AW-1:0] BASE = 8'h00;
  localparam logic [NR-1:0] RO   = 4'b0100;

  logic             clk = 1'b0;
  logic             rst;
  logic             CS_, OE_, WR_;
  logic [AW-1:0]    Addr;
  logic [DW-1:0]    evt_in;
  logic [NR*DW-1:0] reg_q;
  logic             wr_pulse, rd_pulse, irq;
  wire  [DW-1:0]    data_bus;
  logic             tb_drv_en;
  logic [DW-1:0]    tb_drv;

  assign data_bus = tb_drv_en ? tb_drv : 'z;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mdl_regs [NR];
  logic [DW-1:0] d3;
  int            pulses;

  bus_reg_bank #(
    .DW(DW), .AW(AW), .NUM_REGS(NR), .BASE_ADDR(BASE), .RO_MASK(RO), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .rst(rst), .CS_(CS_), .OE_(OE_), .WR_(WR_), .Addr(Addr),
    .data_bus(data_bus), .evt_in(evt_in), .reg_q(reg_q),
    .wr_pulse(wr_pulse), .rd_pulse(rd_pulse), .irq(irq)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++)
      check($sformatf("%s_reg%0d", tag, i), reg_q[i*DW +: DW], mdl_regs[i]);
  endtask

  task automatic bus_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    bit            seen;
    logic [DW-1:0] dummy;
    exp_q.push_back(exp);
    Addr = a;
    CS_  = 1'b0;
    tick(S + 1);
    OE_  = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick(1);
      if (rd_pulse) begin
        seen = 1'b1;
        check(tag, data_bus, exp_q.pop_front());
      end
    end
    check({tag, "_rd_pulse"}, 8'(seen), 8'h01);
    if (!seen) dummy = exp_q.pop_front();
    OE_ = 1'b1;
    tick(1);
    CS_ = 1'b1;
    tick(S + 2);
  endtask

  task automatic bus_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int exp_pulses, input logic [DW-1:0] evt_val, input bit cs_glitch);
    int first;
    Addr      = a;
    tb_drv    = d;
    tb_drv_en = 1'b1;
    CS_       = 1'b0;
    tick(S + 1);
    WR_ = 1'b0;
    tick(2);
    if (cs_glitch) begin
      CS_ = 1'b1;
      tick(S + 1);
      CS_ = 1'b0;
      tick(S + 1);
    end else begin
      tick(2);
    end
    WR_    = 1'b1;
    pulses = 0;
    first  = 0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (wr_pulse) begin
        pulses++;
        if (first == 0) first = k;
      end
      evt_in = (k == LAT - 1) ? evt_val : '0;
    end
    evt_in = '0;
    check({tag, "_pulses"}, 8'(pulses), 8'(exp_pulses));
    if (exp_pulses == 1) check({tag, "_latency"}, 8'(first), 8'(LAT));
    CS_       = 1'b1;
    tb_drv_en = 1'b0;
    tick(S + 2);
  endtask

  initial begin
    rst = 1'b1; CS_ = 1'b1; OE_ = 1'b1; WR_ = 1'b1;
    Addr = '0; evt_in = '0; tb_drv_en = 1'b0; tb_drv = '0;
    for (int i = 0; i < NR; i++) mdl_regs[i] = '0;
    tick(4);

    // reset state
    check_regs("reset");
    check("reset_irq", 8'(irq), 8'h00);
    n_cmp++;
    assert (data_bus === 8'bz) else begin
      n_err++;
      $error("FAIL reset_bus: observed %h, expected z", data_bus);
    end
    rst = 1'b0;
    tick(S + 3);
    bus_read("rd_base", BASE, 8'h00);

    // plain write and read-back
    bus_write("wr_r1", BASE + 8'd1, 8'hA5, 1, 8'h00, 1'b0);
    mdl_regs[1] = 8'hA5;
    check_regs("after_wr_r1");
    bus_read("rd_r1", BASE + 8'd1, 8'hA5);

    // read-only register drops data but still pulses
    bus_write("wr_ro2", BASE + 8'd2, 8'h3C, 1, 8'h00, 1'b0);
    check_regs("after_ro2");
    bus_read("rd_r2", BASE + 8'd2, 8'h00);

    d3 = 8'($urandom_range(1, 255));
    bus_write("wr_r3", BASE + 8'd3, d3, 1, 8'h00, 1'b0);
    mdl_regs[3] = d3;
    check_regs("after_wr_r3");
    bus_read("rd_r3", BASE + 8'd3, d3);

    // unmapped offset
    bus_write("wr_unmapped", BASE + 8'h10, 8'hFF, 0, 8'h00, 1'b0);
    check_regs("after_unmapped");
    bus_read("rd_unmapped", BASE + 8'h10, 8'h00);

    // STATUS events, IRQ_EN, W1C
    bus_write("wr_ien", BASE + 8'd5, 8'h01, 1, 8'h00, 1'b0);
    bus_read("rd_ien", BASE + 8'd5, 8'h01);
    evt_in = 8'h81;
    tick(1);
    evt_in = '0;
    tick(2);
    check("irq_set", 8'(irq), 8'h01);
    bus_read("rd_stat81", BASE + 8'd4, 8'h81);
    bus_write("w1c_01", BASE + 8'd4, 8'h01, 1, 8'h00, 1'b0);
    bus_read("rd_stat80", BASE + 8'd4, 8'h80);
    check("irq_clr", 8'(irq), 8'h00);

    // W1C coincident with a new event: set wins
    bus_write("w1c_80_evt", BASE + 8'd4, 8'h80, 1, 8'h80, 1'b0);
    bus_read("rd_stat_keep", BASE + 8'd4, 8'h80);
    bus_write("w1c_80", BASE + 8'd4, 8'h80, 1, 8'h00, 1'b0);
    bus_read("rd_stat00", BASE + 8'd4, 8'h00);

    // CS_ high mid-strobe aborts the write
    bus_write("wr_abort", BASE, 8'h77, 0, 8'h00, 1'b1);
    check_regs("after_abort");

    // reset while WR_ is low, released before WR_ rises
    Addr      = BASE;
    tb_drv    = 8'h5A;
    tb_drv_en = 1'b1;
    CS_       = 1'b0;
    tick(S + 1);
    WR_ = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    WR_    = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      if (wr_pulse) pulses++;
    end
    check("rst_mid_pulses", 8'(pulses), 8'h00);
    CS_       = 1'b1;
    tb_drv_en = 1'b0;
    tick(S + 2);
    for (int i = 0; i < NR; i++) mdl_regs[i] = '0;
    check_regs("after_rst_mid");
    check("rst_mid_irq", 8'(irq), 8'h00);
    n_cmp++;
    assert (data_bus === 8'bz) else begin
      n_err++;
      $error("FAIL rst_mid_bus: observed %h, expected z", data_bus);
    end
    bus_read("rd_after_rst", BASE + 8'd1, 8'h00);
    bus_read("rd_ien_after_rst", BASE + 8'd5, 8'h00);
    check("sb_empty", 8'(exp_q.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
